// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-stage redirects,
// and RAM/stdout handshakes with a wait timeout that parks the core in a sticky ERROR state.
module pipeline_hazard_controller #(
   parameter logic [1:0] LOAD_SRC    = 2'd1,
   parameter int         TIMEOUT     = 1024,
   parameter int         COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             id_rs1_address,
   input  logic [4:0]             id_rs2_address,
   input  logic                   id_uses_rs1,
   input  logic                   id_uses_rs2,
   input  logic [4:0]             ex_rd_address,
   input  logic                   ex_reg_write_enable,
   input  logic [1:0]             ex_reg_write_data_src,
   input  logic                   mem_redirect,
   input  logic                   mem_ram_access,
   input  logic                   mem_stdout_write_enable,
   input  logic                   ram_ready,
   input  logic                   stdout_ready,
   output logic                   pc_write_enable,
   output logic                   if_id_write_enable,
   output logic                   id_ex_write_enable,
   output logic                   ex_mem_write_enable,
   output logic                   mem_wb_write_enable,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic                   ex_mem_flush,
   output logic                   ram_request,
   output logic                   stdout_request,
   output logic                   error,
   output logic [COUNT_WIDTH-1:0] stall_count
);

   localparam int WAIT_WIDTH = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_ERROR    = 2'd2
   } state_t;

   state_t                state, next_state;
   logic [WAIT_WIDTH-1:0] wait_count, wait_next;
   logic                  mem_op, ready_ok, mem_stall, load_use, stall_cycle;

   assign mem_op   = mem_ram_access | mem_stdout_write_enable;
   assign ready_ok = (!mem_ram_access | ram_ready) & (!mem_stdout_write_enable | stdout_ready);

   assign load_use = ex_reg_write_enable && (ex_reg_write_data_src == LOAD_SRC) &&
                     (ex_rd_address != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1_address == ex_rd_address)) ||
                      (id_uses_rs2 && (id_rs2_address == ex_rd_address)));

   // NOTE: every output and next-state term gets a default first so no path infers a latch.
   always_comb begin
      next_state          = state;
      wait_next           = wait_count;
      mem_stall           = 1'b0;
      stall_cycle         = 1'b0;
      pc_write_enable     = 1'b0;
      if_id_write_enable  = 1'b0;
      id_ex_write_enable  = 1'b0;
      ex_mem_write_enable = 1'b0;
      mem_wb_write_enable = 1'b0;
      if_id_flush         = 1'b0;
      id_ex_flush         = 1'b0;
      ex_mem_flush        = 1'b0;
      ram_request         = 1'b0;
      stdout_request      = 1'b0;

      if (reset) begin
         next_state = S_RUN;
      end else begin
         case (state)
            S_RUN, S_MEM_WAIT: begin
               ram_request    = mem_ram_access;
               stdout_request = mem_stdout_write_enable;
               mem_stall      = mem_op & !ready_ok;
               if (mem_stall) begin
                  // The cycle that first raises the request already counts as wait cycle 1.
                  stall_cycle = 1'b1;
                  wait_next   = (state == S_RUN) ? WAIT_WIDTH'(1) : wait_count + WAIT_WIDTH'(1);
                  next_state  = (wait_next >= WAIT_WIDTH'(TIMEOUT)) ? S_ERROR : S_MEM_WAIT;
               end else begin
                  next_state          = S_RUN;
                  pc_write_enable     = 1'b1;
                  if_id_write_enable  = 1'b1;
                  id_ex_write_enable  = 1'b1;
                  ex_mem_write_enable = 1'b1;
                  mem_wb_write_enable = 1'b1;
                  if (mem_redirect) begin
                     if_id_flush  = 1'b1;
                     id_ex_flush  = 1'b1;
                     ex_mem_flush = 1'b1;
                  end else if (load_use) begin
                     stall_cycle        = 1'b1;
                     pc_write_enable    = 1'b0;
                     if_id_write_enable = 1'b0;
                     id_ex_flush        = 1'b1;
                  end
               end
            end
            S_ERROR: stall_cycle = 1'b1;
            default: next_state = S_RUN;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_RUN;
         wait_count  <= '0;
         error       <= 1'b0;
         stall_count <= '0;
      end else begin
         state      <= next_state;
         wait_count <= wait_next;
         error      <= (next_state == S_ERROR);
         if (stall_cycle && (stall_count != {COUNT_WIDTH{1'b1}}))
            stall_count <= stall_count + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: load-use, redirect, memory waits, timeout,
// saturation of a narrow stall counter, and reset out of MEM_WAIT / ERROR.
module tb_pipeline_hazard_controller;

   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic [4:0]    id_rs1_address, id_rs2_address, ex_rd_address;
   logic          id_uses_rs1, id_uses_rs2, ex_reg_write_enable;
   logic [1:0]    ex_reg_write_data_src;
   logic          mem_redirect, mem_ram_access, mem_stdout_write_enable, ram_ready, stdout_ready;
   logic          pc_write_enable, if_id_write_enable, id_ex_write_enable, ex_mem_write_enable;
   logic          mem_wb_write_enable, if_id_flush, id_ex_flush, ex_mem_flush;
   logic          ram_request, stdout_request, error;
   logic [CW-1:0] stall_count;

   int vectors;
   int miscompares;

   // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id/id_ex/ex_mem flushes, ram/stdout requests}
   logic [9:0] ctl;
   assign ctl = {pc_write_enable, if_id_write_enable, id_ex_write_enable, ex_mem_write_enable,
                 mem_wb_write_enable, if_id_flush, id_ex_flush, ex_mem_flush,
                 ram_request, stdout_request};

   localparam logic [9:0] ALL_EN = 10'b11111_000_00;
   localparam logic [9:0] LU     = 10'b00111_010_00;
   localparam logic [9:0] REDIR  = 10'b11111_111_00;
   localparam logic [9:0] FRZ    = 10'b00000_000_00;

   pipeline_hazard_controller #(
      .LOAD_SRC(2'd1), .TIMEOUT(4), .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset),
      .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd_address(ex_rd_address), .ex_reg_write_enable(ex_reg_write_enable),
      .ex_reg_write_data_src(ex_reg_write_data_src),
      .mem_redirect(mem_redirect), .mem_ram_access(mem_ram_access),
      .mem_stdout_write_enable(mem_stdout_write_enable),
      .ram_ready(ram_ready), .stdout_ready(stdout_ready),
      .pc_write_enable(pc_write_enable), .if_id_write_enable(if_id_write_enable),
      .id_ex_write_enable(id_ex_write_enable), .ex_mem_write_enable(ex_mem_write_enable),
      .mem_wb_write_enable(mem_wb_write_enable),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
      .ram_request(ram_request), .stdout_request(stdout_request),
      .error(error), .stall_count(stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1_address = 5'd0; id_rs2_address = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd_address = 5'd0; ex_reg_write_enable = 1'b0; ex_reg_write_data_src = 2'd0;
      mem_redirect = 1'b0; mem_ram_access = 1'b0; mem_stdout_write_enable = 1'b0;
      ram_ready = 1'b0; stdout_ready = 1'b0;
   endtask

   task automatic set_hazard();
      ex_reg_write_enable = 1'b1; ex_reg_write_data_src = 2'd1; ex_rd_address = 5'd5;
      id_uses_rs2 = 1'b1; id_rs2_address = 5'd5;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      idle();
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      cyc();
      cyc();
      mem_redirect = 1'b1; mem_ram_access = 1'b1; ram_ready = 1'b1;
      #1;
      vectors++;
      if (ctl !== FRZ) begin
         miscompares++; $display("FAIL reset_outputs got %b want %b", ctl, FRZ);
      end
      vectors++;
      if ({error, stall_count} !== {1'b0, CW'(0)}) begin
         miscompares++; $display("FAIL reset_regs got err=%b cnt=%0d want err=0 cnt=0", error, stall_count);
      end
      idle();
      cyc();
      reset = 1'b0;
   endtask

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, we;
      logic [1:0] src;
      logic       hz;
   } lu_vec_t;

   task automatic test_load_use();
      lu_vec_t tab [7];
      int      cnt = 0;
      tab = '{
         '{rs1:5'd3,  rs2:5'd5,  rd:5'd5,  u1:1'b1, u2:1'b1, we:1'b1, src:2'd1, hz:1'b1},
         '{rs1:5'd0,  rs2:5'd0,  rd:5'd0,  u1:1'b1, u2:1'b1, we:1'b1, src:2'd1, hz:1'b0},
         '{rs1:5'd3,  rs2:5'd5,  rd:5'd5,  u1:1'b1, u2:1'b0, we:1'b1, src:2'd1, hz:1'b0},
         '{rs1:5'd7,  rs2:5'd2,  rd:5'd7,  u1:1'b1, u2:1'b0, we:1'b1, src:2'd1, hz:1'b1},
         '{rs1:5'd9,  rs2:5'd9,  rd:5'd9,  u1:1'b1, u2:1'b1, we:1'b1, src:2'd2, hz:1'b0},
         '{rs1:5'd9,  rs2:5'd9,  rd:5'd9,  u1:1'b1, u2:1'b1, we:1'b0, src:2'd1, hz:1'b0},
         '{rs1:5'd31, rs2:5'd31, rd:5'd31, u1:1'b1, u2:1'b1, we:1'b1, src:2'd1, hz:1'b1}
      };
      for (int i = 0; i < 7; i++) begin
         cyc();
         id_rs1_address = tab[i].rs1; id_rs2_address = tab[i].rs2; ex_rd_address = tab[i].rd;
         id_uses_rs1 = tab[i].u1; id_uses_rs2 = tab[i].u2;
         ex_reg_write_enable = tab[i].we; ex_reg_write_data_src = tab[i].src;
         #1;
         vectors++;
         if (ctl !== (tab[i].hz ? LU : ALL_EN)) begin
            miscompares++;
            $display("FAIL load_use_case%0d got %b want %b", i, ctl, tab[i].hz ? LU : ALL_EN);
         end
         if (tab[i].hz) cnt++;
         cyc();
         idle();
         #1;
         vectors++;
         if ({ctl, stall_count} !== {ALL_EN, CW'(cnt)}) begin
            miscompares++;
            $display("FAIL load_use_after%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                     i, ctl, stall_count, ALL_EN, cnt);
         end
      end
   endtask

   task automatic test_mem_wait();
      reset_dut();
      mem_ram_access = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if ({ctl, stall_count} !== {10'b00000_000_10, CW'(i)}) begin
            miscompares++;
            $display("FAIL ram_wait%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                     i, ctl, stall_count, 10'b00000_000_10, i);
         end
         cyc();
         mem_ram_access = 1'b1;
      end
      ram_ready = 1'b1;
      #1;
      vectors++;
      if ({ctl, stall_count} !== {10'b11111_000_10, CW'(3)}) begin
         miscompares++; $display("FAIL ram_done got ctl=%b cnt=%0d want ctl=1111100010 cnt=3", ctl, stall_count);
      end
      // Zero-wait completion in RUN.
      cyc();
      #1;
      vectors++;
      if ({ctl, stall_count} !== {10'b11111_000_10, CW'(3)}) begin
         miscompares++; $display("FAIL ram_zero_wait got ctl=%b cnt=%0d want ctl=1111100010 cnt=3", ctl, stall_count);
      end
      // Both accesses: ram ready, stdout not yet.
      cyc();
      mem_stdout_write_enable = 1'b1; stdout_ready = 1'b0;
      #1;
      vectors++;
      if (ctl !== 10'b00000_000_11) begin
         miscompares++; $display("FAIL dual_wait got %b want 0000000011", ctl);
      end
      cyc();
      stdout_ready = 1'b1;
      #1;
      vectors++;
      if ({ctl, stall_count} !== {10'b11111_000_11, CW'(4)}) begin
         miscompares++; $display("FAIL dual_done got ctl=%b cnt=%0d want ctl=1111100011 cnt=4", ctl, stall_count);
      end
      // Load-use pending behind a memory wait: freeze first, bubble on completion.
      cyc();
      idle();
      set_hazard();
      mem_ram_access = 1'b1;
      #1;
      vectors++;
      if (ctl !== 10'b00000_000_10) begin
         miscompares++; $display("FAIL wait_over_lu got %b want 0000000010", ctl);
      end
      cyc();
      ram_ready = 1'b1;
      #1;
      vectors++;
      if ({ctl, stall_count} !== {10'b00111_010_10, CW'(5)}) begin
         miscompares++; $display("FAIL lu_after_wait got ctl=%b cnt=%0d want ctl=0011101010 cnt=5", ctl, stall_count);
      end
      cyc();
      idle();
      #1;
      vectors++;
      if ({ctl, stall_count} !== {ALL_EN, CW'(6)}) begin
         miscompares++; $display("FAIL lu_after_wait_next got ctl=%b cnt=%0d want ctl=%b cnt=6", ctl, stall_count, ALL_EN);
      end
   endtask

   task automatic test_redirect();
      reset_dut();
      set_hazard();
      mem_redirect = 1'b1;
      #1;
      vectors++;
      if (ctl !== REDIR) begin
         miscompares++; $display("FAIL redirect_over_lu got %b want %b", ctl, REDIR);
      end
      cyc();
      idle();
      mem_redirect = 1'b1; mem_ram_access = 1'b1;
      #1;
      vectors++;
      if ({ctl, stall_count} !== {10'b00000_000_10, CW'(0)}) begin
         miscompares++; $display("FAIL redirect_in_wait got ctl=%b cnt=%0d want ctl=0000000010 cnt=0", ctl, stall_count);
      end
      cyc();
      ram_ready = 1'b1;
      #1;
      vectors++;
      if ({ctl, stall_count} !== {10'b11111_111_10, CW'(1)}) begin
         miscompares++; $display("FAIL redirect_done got ctl=%b cnt=%0d want ctl=1111111110 cnt=1", ctl, stall_count);
      end
   endtask

   task automatic test_timeout();
      reset_dut();
      mem_stdout_write_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if ({ctl, error, stall_count} !== {10'b00000_000_01, 1'b0, CW'(i)}) begin
            miscompares++;
            $display("FAIL timeout_wait%0d got ctl=%b err=%b cnt=%0d want ctl=0000000001 err=0 cnt=%0d",
                     i, ctl, error, stall_count, i);
         end
         cyc();
      end
      #1;
      vectors++;
      if ({ctl, error, stall_count} !== {FRZ, 1'b1, CW'(4)}) begin
         miscompares++; $display("FAIL timeout_error got ctl=%b err=%b cnt=%0d want ctl=0 err=1 cnt=4", ctl, error, stall_count);
      end
      stdout_ready = 1'b1;
      cyc();
      #1;
      vectors++;
      if ({ctl, error, stall_count} !== {FRZ, 1'b1, CW'(5)}) begin
         miscompares++; $display("FAIL error_sticky got ctl=%b err=%b cnt=%0d want ctl=0 err=1 cnt=5", ctl, error, stall_count);
      end
      for (int i = 0; i < 12; i++) cyc();
      vectors++;
      if (stall_count !== CW'(15)) begin
         miscompares++; $display("FAIL count_saturate got %0d want 15", stall_count);
      end
      reset = 1'b1;
      idle();
      cyc();
      reset = 1'b0;
      #1;
      vectors++;
      if ({ctl, error, stall_count} !== {ALL_EN, 1'b0, CW'(0)}) begin
         miscompares++; $display("FAIL error_reset got ctl=%b err=%b cnt=%0d want ctl=%b err=0 cnt=0", ctl, error, stall_count, ALL_EN);
      end
   endtask

   task automatic test_reset_mid_wait();
      reset_dut();
      mem_ram_access = 1'b1;
      cyc();
      cyc();
      reset = 1'b1;
      #1;
      vectors++;
      if (ctl !== FRZ) begin
         miscompares++; $display("FAIL reset_in_wait got %b want %b", ctl, FRZ);
      end
      cyc();
      reset = 1'b0;
      idle();
      #1;
      vectors++;
      if ({ctl, error, stall_count} !== {ALL_EN, 1'b0, CW'(0)}) begin
         miscompares++; $display("FAIL after_wait_reset got ctl=%b err=%b cnt=%0d want ctl=%b err=0 cnt=0", ctl, error, stall_count, ALL_EN);
      end
      // A fresh wait must take the full timeout again.
      mem_ram_access = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      vectors++;
      if ({ctl, error} !== {10'b00000_000_10, 1'b0}) begin
         miscompares++; $display("FAIL fresh_wait got ctl=%b err=%b want ctl=0000000010 err=0", ctl, error);
      end
      cyc();
      vectors++;
      if ({ctl, error} !== {FRZ, 1'b1}) begin
         miscompares++; $display("FAIL fresh_timeout got ctl=%b err=%b want ctl=0 err=1", ctl, error);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_mem_wait();
      test_redirect();
      test_timeout();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Drives write_enable of the PC and every pipeline register, plus the bubble-insert (flush) controls.
- Handles three hazard classes: load-use hazards, PC redirects resolved in MEM, and RAM/stdout access handshakes with timeout.
- Sits in the top-level core beside the pipeline registers; purely control, no datapath.

Parameters:
- LOAD_SRC, 2'd1, reg_write_data_src encoding meaning "write-back data comes from RAM" (i.e. the instruction is a load).
- TIMEOUT, 1024, maximum MEM_WAIT cycles before entering ERROR.
- COUNT_WIDTH, 32, width of stall_count.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- id_rs1_address  input  5  rs1 of the instruction in ID.
- id_rs2_address  input  5  rs2 of the instruction in ID.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_rd_address  input  5  rd of the instruction in EX.
- ex_reg_write_enable  input  1  EX instruction writes rd.
- ex_reg_write_data_src  input  2  EX write-back source.
- mem_redirect  input  1  instruction in MEM redirects the PC (taken branch or jump).
- mem_ram_access  input  1  MEM instruction reads or writes RAM.
- mem_stdout_write_enable  input  1  MEM instruction writes stdout.
- ram_ready  input  1  RAM completes the request this cycle.
- stdout_ready  input  1  stdout accepts the byte this cycle.
- pc_write_enable  output  1  PC update enable.
- if_id_write_enable  output  1  IF/ID register enable.
- id_ex_write_enable  output  1  ID/EX register enable.
- ex_mem_write_enable  output  1  EX/MEM register enable.
- mem_wb_write_enable  output  1  MEM/WB register enable.
- if_id_flush  output  1  load a bubble into IF/ID (valid only with its write_enable).
- id_ex_flush  output  1  load a bubble into ID/EX (valid only with its write_enable).
- ex_mem_flush  output  1  load a bubble into EX/MEM (valid only with its write_enable).
- ram_request  output  1  RAM access request.
- stdout_request  output  1  stdout write request.
- error  output  1  sticky timeout flag.
- stall_count  output  COUNT_WIDTH  saturating count of stall cycles.

Behaviour:

States: RUN, MEM_WAIT, ERROR. All outputs are combinational from state and inputs, except error and stall_count, which are registered.

Reset (reset=1 at a clk edge):
- Next state is RUN; error cleared to 0; stall_count cleared to 0.
- While reset is high, all enables, flushes and requests are forced to 0.

Derived terms:
- mem_op = mem_ram_access | mem_stdout_write_enable.
- ready_ok = (!mem_ram_access | ram_ready) & (!mem_stdout_write_enable | stdout_ready).
- ram_request = mem_ram_access in RUN or MEM_WAIT.
- stdout_request = mem_stdout_write_enable in RUN or MEM_WAIT.
- Requests stay high until ready. Zero-wait completion is allowed (ready in the same cycle the request first appears).

mem_stall (state RUN or MEM_WAIT):
- Condition: mem_op & !ready_ok.
- Response: every write_enable = 0 and every flush = 0 (full freeze).
- If in RUN, go to MEM_WAIT and load the wait counter with 1.
- In MEM_WAIT, the wait counter increments each stalled cycle. If it reaches TIMEOUT while still not ready, go to ERROR.

Memory completion:
- In MEM_WAIT with ready_ok=1: return to RUN, and this cycle follows the RUN rules below.

ERROR:
- Full freeze, requests 0, error=1.
- Held until reset.

RUN priority when not mem_stall (highest first):
1. mem_redirect: all write_enables = 1; if_id_flush = id_ex_flush = ex_mem_flush = 1. The three younger instructions are squashed. Redirect overrides load-use.
2. Load-use: condition is ex_reg_write_enable & ex_reg_write_data_src==LOAD_SRC & ex_rd_address!=0 & ((id_uses_rs1 & id_rs1_address==ex_rd_address) | (id_uses_rs2 & id_rs2_address==ex_rd_address)). Response: pc_write_enable = if_id_write_enable = 0; id_ex_write_enable = 1 with id_ex_flush = 1; ex_mem and mem_wb enables = 1. Exactly one bubble per hazard; the following cycle has no hazard because EX then holds the bubble.
3. Otherwise: all write_enables = 1, all flushes = 0.

stall_count:
- Increments by 1 on every cycle with mem_stall, load-use, or ERROR freeze.
- Saturates at all-ones and does not wrap.

Reset asserted mid-MEM_WAIT or during ERROR: next state RUN, error cleared to 0, stall_count cleared to 0.

Test Plan:
- Load x5 in EX, ID add uses rs2=x5 -> one cycle: pc/if_id enables 0, id_ex_flush 1; next cycle all enables 1; stall_count=1.
- Same as previous but ex_rd_address=0, or id_uses_rs2=0 -> no stall, all enables 1.
- mem_ram_access=1, ram_ready low for 3 cycles then high -> 3 full-freeze cycles with ram_request held at 1; enables 1 on cycle 4; stall_count=3.
- mem_redirect=1 together with a load-use hazard -> all enables 1, three flushes 1, no load-use bubble.
- mem_stdout_write_enable=1, stdout_ready held 0, TIMEOUT=4 -> enter ERROR after 4 wait cycles; error=1, requests 0; reset -> RUN, error 0.
- reset=1 during MEM_WAIT -> next cycle state RUN, stall_count 0, no request until a new mem_op.
